// File: rtl/bb_share_arb.sv
// bb_share_arb: shares one registered bit-op unit among NREQ requesters; define BB_SHARE_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin
module bb_share_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op_a,
    input  logic [NREQ-1:0] op_b,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            unit_in1,
    output logic            unit_in2,
    input  logic            unit_out,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_data
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [2:0] LAT_C = 3'(LAT);
    state_t         state, state_nx;
    logic [IDW-1:0] ptr, id, sel;
    logic [2:0]     cnt;
    logic           found;
    int             k;

    // first requester at or above the pointer, wrapping past NREQ-1
    always_comb begin
        found = 1'b0;
        sel   = '0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!found && |(req & (NREQ'(1) << k))) begin
                found = 1'b1;
                sel   = k[IDW-1:0];
            end
        end
    end

    // next state and state-decoded outputs; the unit result is already valid in RESP
    always_comb begin
        state_nx  = state;
        if (state == IDLE && found) state_nx = WAIT;
        if (state == WAIT && cnt == 3'd1) state_nx = RESP;
        if (state == RESP) state_nx = IDLE;
        busy      = state != IDLE;
        gnt       = (state == WAIT && cnt == LAT_C) ? NREQ'(1) << id : '0;
        rsp_valid = state == RESP;
        rsp_id    = rsp_valid ? id : '0;
        rsp_data  = rsp_valid & unit_out;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // capture winner and operands, count the unit latency, advance the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id       <= '0;
            cnt      <= '0;
            ptr      <= '0;
            unit_in1 <= 1'b0;
            unit_in2 <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                id       <= sel;
                cnt      <= LAT_C;
                unit_in1 <= |(op_a & (NREQ'(1) << sel));
                unit_in2 <= |(op_b & (NREQ'(1) << sel));
            end
            if (state == WAIT) cnt <= cnt - 3'd1;
`ifdef BB_SHARE_ARB_FIXED_PRIO_EN
            ptr <= '0;
`else
            if (state == RESP) ptr <= (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
`endif
        end
    end
endmodule

// File: tb/tb_bb_share_arb.sv
// tb_bb_share_arb: two instances (LAT=1, LAT=3) with behavioural unit models, checked per op against a transaction-level arbitration model
module tb_bb_share_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] req1, a1, b1, gnt1, req3, a3, b3, gnt3;
    logic       busy1, in11, in21, out1, rv1, rd1;
    logic       busy3, in13, in23, out3, rv3, rd3;
    logic [1:0] id1, id3;

    logic [3:0] o_gnt;
    logic       o_busy, o_in1, o_in2, o_rv, o_rd;
    logic [1:0] o_id;

    int n_checks = 0;
    int n_fail = 0;
    int m_ptr [2];

    bb_share_arb #(.NREQ(4), .LAT(1), .IDW(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .op_a(a1), .op_b(b1), .gnt(gnt1), .busy(busy1),
        .unit_in1(in11), .unit_in2(in21), .unit_out(out1), .rsp_valid(rv1), .rsp_id(id1), .rsp_data(rd1)
    );
    bb_share_arb #(.NREQ(4), .LAT(3), .IDW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .op_a(a3), .op_b(b3), .gnt(gnt3), .busy(busy3),
        .unit_in1(in13), .unit_in2(in23), .unit_out(out3), .rsp_valid(rv3), .rsp_id(id3), .rsp_data(rd3)
    );

    // shared black-box units: one-cycle registered AND
    always @(posedge clk) out1 <= in11 & in21;
    always @(posedge clk) out3 <= in13 & in23;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (((r >> ((p + i) % 4)) & 4'd1) != 4'd0) return (p + i) % 4;
        return -1;
    endfunction

    function automatic int next_ptr(input int w);
`ifdef BB_SHARE_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (w + 1) % 4;
`endif
    endfunction

    task automatic sample(input bit s);
        o_gnt  = s ? gnt3 : gnt1;
        o_busy = s ? busy3 : busy1;
        o_in1  = s ? in13 : in11;
        o_in2  = s ? in23 : in21;
        o_rv   = s ? rv3 : rv1;
        o_id   = s ? id3 : id1;
        o_rd   = s ? rd3 : rd1;
    endtask

    // one full transaction from the IDLE cycle that sees req through the following IDLE cycle
    task automatic do_op(input bit s, input logic [3:0] r, input logic [3:0] a, input logic [3:0] b);
        int lat, w;
        logic ea, eb;
        lat = s ? 3 : 1;
        if (s) begin req3 = r; a3 = a; b3 = b; req1 = '0; end
        else   begin req1 = r; a1 = a; b1 = b; req3 = '0; end
        w  = pick(r, m_ptr[s]);
        ea = |((a >> w) & 4'd1);
        eb = |((b >> w) & 4'd1);
        @(posedge clk); #1; sample(s);
        n_checks++; if (o_gnt !== 4'(1 << w)) begin n_fail++; $display("FAIL gnt lat%0d: got %b want %b", lat, o_gnt, 4'(1 << w)); end
        n_checks++; if (o_in1 !== ea) begin n_fail++; $display("FAIL unit_in1 lat%0d: got %b want %b", lat, o_in1, ea); end
        n_checks++; if (o_in2 !== eb) begin n_fail++; $display("FAIL unit_in2 lat%0d: got %b want %b", lat, o_in2, eb); end
        n_checks++; if (o_busy !== 1'b1 || o_rv !== 1'b0) begin n_fail++; $display("FAIL wait1 lat%0d: busy %b rv %b want 1 0", lat, o_busy, o_rv); end
        for (int c = 2; c <= lat; c++) begin
            @(posedge clk); #1; sample(s);
            n_checks++; if (o_gnt !== 4'b0 || o_rv !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL wait%0d lat%0d: gnt %b rv %b busy %b want 0000 0 1", c, lat, o_gnt, o_rv, o_busy); end
            n_checks++; if (o_in1 !== ea || o_in2 !== eb) begin n_fail++; $display("FAIL unit_in stable c%0d lat%0d: got %b%b want %b%b", c, lat, o_in1, o_in2, ea, eb); end
        end
        @(posedge clk); #1; sample(s);
        n_checks++; if (o_rv !== 1'b1) begin n_fail++; $display("FAIL rsp_valid lat%0d: got %b want 1", lat, o_rv); end
        n_checks++; if (o_id !== 2'(w)) begin n_fail++; $display("FAIL rsp_id lat%0d: got %0d want %0d", lat, o_id, w); end
        n_checks++; if (o_rd !== (ea & eb)) begin n_fail++; $display("FAIL rsp_data lat%0d: got %b want %b", lat, o_rd, ea & eb); end
        n_checks++; if (o_gnt !== 4'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL resp gnt/busy lat%0d: got %b %b want 0000 1", lat, o_gnt, o_busy); end
        m_ptr[s] = next_ptr(w);
        @(posedge clk); #1; sample(s);
        n_checks++; if (o_busy !== 1'b0 || o_rv !== 1'b0) begin n_fail++; $display("FAIL post idle lat%0d: busy %b rv %b want 0 0", lat, o_busy, o_rv); end
    endtask

    task automatic idle(input bit s);
        req1 = '0; req3 = '0;
        @(posedge clk); #1; sample(s);
        n_checks++; if (o_busy !== 1'b0 || o_gnt !== 4'b0 || o_rv !== 1'b0) begin n_fail++; $display("FAIL idle: busy %b gnt %b rv %b want 0 0000 0", o_busy, o_gnt, o_rv); end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if ({gnt1, busy1, in11, in21, rv1, id1, rd1} !== 11'b0) begin n_fail++; $display("FAIL reset dut1: got %b want 0", {gnt1, busy1, in11, in21, rv1, id1, rd1}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req3 = 4'b0010; a3 = 4'b1111; b3 = 4'b1111;
        @(posedge clk); #1;
        n_checks++; if (gnt3 !== 4'b0010) begin n_fail++; $display("FAIL pre-abort gnt: got %b want 0010", gnt3); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({gnt3, busy3, in13, in23, rv3, id3, rd3} !== 11'b0) begin n_fail++; $display("FAIL async reset dut3: got %b want 0", {gnt3, busy3, in13, in23, rv3, id3, rd3}); end
        req3 = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        m_ptr[0] = 0; m_ptr[1] = 0;
        repeat (6) begin
            @(posedge clk); #1;
            n_checks++; if (rv3 !== 1'b0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL aborted op: rv %b busy %b want 0 0", rv3, busy3); end
        end
    endtask

    task automatic test_fairness();
        repeat (5) do_op(0, 4'b1111, 4'b1111, 4'b0000);
        idle(0);
    endtask

    task automatic test_single();
        do_op(0, 4'b0100, 4'b0100, 4'b0100);
        idle(0);
    endtask

    task automatic test_wrap();
        do_op(0, 4'b1001, 4'b1001, 4'b1000);
        do_op(0, 4'b1001, 4'b1001, 4'b1000);
        idle(0);
    endtask

    task automatic test_latency();
        do_op(1, 4'b0001, 4'b1111, 4'b1111);
        idle(1);
        repeat (4) do_op(1, 4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom));
        idle(1);
    endtask

    task automatic test_held_pair();
        repeat (4) do_op(0, 4'b1010, 4'($urandom), 4'($urandom));
        idle(0);
    endtask

    task automatic test_random();
        logic [3:0] r;
        bit s;
        repeat (40) begin
            s = 1'($urandom_range(0, 1));
            r = 4'($urandom_range(0, 15));
            if (r == 4'b0) idle(s);
            else do_op(s, r, 4'($urandom), 4'($urandom));
        end
        idle(0);
    endtask

    initial begin
        req1 = '0; a1 = '0; b1 = '0; req3 = '0; a3 = '0; b3 = '0;
        m_ptr[0] = 0; m_ptr[1] = 0;
        test_reset();
        test_fairness();
        test_single();
        test_wrap();
        test_latency();
        test_held_pair();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
